// File: rtl/iram_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the program counter, drives the
// synchronous-read instruction RAM and hands each instruction to the control
// unit over a valid/ready handshake. Branch redirects restart the fetch;
// the halt opcode parks the sequencer until the next start.
module iram_fetch_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] iram_address,
  input  logic [DATA_W-1:0] iram_q,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_OUT,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic in_flight;
  logic start_fetch;
  logic take_redirect;
  logic accept;
  logic is_halt_op;

  // Handshake/event decode shared by the next-state and datapath logic.
  // Redirect outranks acceptance in the same OUT cycle.
  always_comb begin
    in_flight     = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_OUT);
    start_fetch   = ((state_q == S_IDLE) || (state_q == S_HALT)) && start;
    take_redirect = in_flight && redirect;
    accept        = (state_q == S_OUT) && valid_q && instr_ready && !redirect;
    is_halt_op    = (instr_q[DATA_W-1 -: 4] == HALT_OPCODE);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (start_fetch) state_d = S_ADDR;
      S_ADDR:         state_d = take_redirect ? S_ADDR : S_DATA;
      S_DATA:         state_d = take_redirect ? S_ADDR : S_OUT;
      S_OUT: begin
        if (take_redirect)   state_d = S_ADDR;
        else if (accept)     state_d = is_halt_op ? S_HALT : S_ADDR;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and PC.
  always_comb begin
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (start_fetch) begin
      pc_d   = START_ADDR;
      addr_d = START_ADDR;
      cnt_d  = 16'd0;
    end else if (take_redirect) begin
      pc_d    = redirect_addr;
      addr_d  = redirect_addr;
      valid_d = 1'b0;
    end else if (state_q == S_DATA) begin
      // The RAM latched addr_q at the close of ADDR, so q belongs to pc_q.
      instr_d = iram_q;
      ipc_d   = pc_q;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
      cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      if (!is_halt_op) begin
        pc_d   = pc_q + ADDR_W'(1);
        addr_d = pc_q + ADDR_W'(1);
      end
    end
    busy_d   = (state_d == S_ADDR) || (state_d == S_DATA) || (state_d == S_OUT);
    halted_d = (state_d == S_HALT);
  end

  // Output and PC registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= 16'd0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign iram_address = addr_q;
  assign instr_out    = instr_q;
  assign instr_pc     = ipc_q;
  assign instr_valid  = valid_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign fetch_count  = cnt_q;

endmodule

// File: doc/iram_fetch_sequencer.md
Name: iram_fetch_sequencer

Overview:
- Instruction-fetch controller between the processor control unit and the 256-word x 16-bit instruction RAM.
- The IRAM has a registered synchronous read: it latches `address` on the rising edge of `clock` and presents `q` one cycle later.
- Owns the program counter and sequences IRAM reads. Presents each instruction to the control unit over a valid/ready handshake, accepts branch/jump redirects, and stops at the end-of-program opcode.

Parameters:
- ADDR_W, 8, IRAM address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 16, instruction width.
- START_ADDR, 0, PC value loaded on `start`.
- HALT_OPCODE, 4'hF, value of `instr[15:12]` that ends the program.

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin fetching at START_ADDR; sampled only in IDLE or HALT.
- iram_address, output, ADDR_W, registered address to the IRAM `address` input.
- iram_q, input, DATA_W, IRAM read data (`q`).
- instr_out, output, DATA_W, captured instruction.
- instr_pc, output, ADDR_W, address that `instr_out` was fetched from.
- instr_valid, output, 1, `instr_out` is valid.
- instr_ready, input, 1, control unit accepts `instr_out`.
- redirect, input, 1, branch/jump taken.
- redirect_addr, input, ADDR_W, branch/jump target.
- busy, output, 1, high in ADDR, DATA or OUT.
- halted, output, 1, high in HALT.
- fetch_count, output, 16, number of accepted instructions; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-fetch):
  - state = IDLE.
  - pc, iram_address, instr_pc = 0.
  - instr_out = 0, instr_valid = 0.
  - busy = 0, halted = 0, fetch_count = 0.
- States are IDLE, ADDR, DATA, OUT, HALT. All outputs are registered.
- IDLE: on start=1:
  - pc <= START_ADDR, iram_address <= START_ADDR.
  - fetch_count <= 0.
  - next state ADDR.
- ADDR: iram_address is stable; the IRAM latches it at this cycle's closing edge. Next state DATA.
- DATA: iram_q is valid. At the closing edge:
  - instr_out <= iram_q, instr_pc <= pc, instr_valid <= 1.
  - next state OUT.
- OUT: instr_out, instr_pc and instr_valid are held while instr_ready=0. On instr_valid & instr_ready:
  - fetch_count increments, saturating at 16'hFFFF.
  - instr_valid <= 0.
  - If instr_out[15:12] == HALT_OPCODE: next state HALT; pc is unchanged.
  - Otherwise: pc <= pc+1, with 8'hFF wrapping to 8'h00; iram_address <= pc+1; next state ADDR.
- Redirect in ADDR, DATA or OUT:
  - pc <= redirect_addr, iram_address <= redirect_addr, instr_valid <= 0.
  - Next state ADDR. Any in-flight or presented instruction is discarded and not counted.
  - Redirect has priority over acceptance in the same OUT cycle. The instruction is not counted, and a HALT_OPCODE instruction does not halt.
- redirect in IDLE or HALT is ignored.
- HALT:
  - halted=1, instr_valid=0, iram_address holds.
  - On start=1: same action as start in IDLE (restart from START_ADDR, fetch_count cleared).
- start outside IDLE/HALT is ignored.
- Latency:
  - instr_valid rises two edges after the edge that samples start or a redirect.
  - With instr_ready held high, throughput is one instruction per 3 cycles.
- busy = (state is ADDR, DATA or OUT). halted and busy are never both 1.

Test Plan:
- Straight-line fetch. Bench IRAM model: [0]=16'hC07F, [1]=16'h3102, [2]=16'hF000. Pulse start, hold ready=1 → instr_valid rises 2 edges after the start edge. Observe (pc, instr): (0, C07F), (1, 3102), (2, F000), with valid pulses 3 cycles apart. Then halted=1, busy=0, fetch_count=3.
- Backpressure: hold ready=0 for 5 cycles while presenting addr 1 → instr_out stays 16'h3102 and instr_pc stays 1. iram_address does not advance. Accepted exactly once when ready goes high.
- Redirect: assert redirect with redirect_addr=8'h20 in the same OUT cycle as ready=1 for the instruction at addr 1 → that instruction is not counted and the next valid instruction has instr_pc=8'h20. Repeat the redirect in the DATA state → no valid pulse for the discarded fetch.
- Wrap-around: START_ADDR=8'hFE, non-halt words at FE and FF → instr_pc sequence FE, FF, 00.
- Halt and restart: after halted=1, pulse redirect → ignored. Pulse start → fetch resumes at START_ADDR and fetch_count restarts from 0.
- Reset mid-fetch: drop reset_n low during DATA → all outputs are at reset values immediately, without waiting for a clock edge. After reset_n is released, the block stays in IDLE until start.
